div_calc: RTL and testbench
===========================

# div_calc

Sequential 32-bit signed integer divider for the multdiv unit, the inverse-operation counterpart to the combinational add/subtract datapath. It takes a one-cycle start pulse with dividend and divisor and runs a restoring shift-subtract loop, one quotient bit per cycle. It returns the quotient and remainder with a one-cycle ready pulse. Divide-by-zero and the single overflow case are flagged as exceptions.

## Interface
- WIDTH, 32: operand and result width. Only 32 is verified.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_DIV  in  1  start pulse, sampled each rising edge.
- data_operandA  in  WIDTH  dividend (two's complement), sampled when ctrl_DIV=1.
- data_operandB  in  WIDTH  divisor (two's complement), sampled when ctrl_DIV=1.
- data_result  out  WIDTH  quotient, registered, held until the next start or reset.
- data_remainder  out  WIDTH  remainder, registered, held like data_result.
- data_exception  out  1  divide-by-zero or overflow, valid while data_resultRDY=1, held afterwards.
- data_resultRDY  out  1  one-cycle pulse when outputs become valid.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - ctrl_DIV=1 with B≠0 and not (A=0x80000000 and B=0xFFFFFFFF):
    - latch |A|, |B|, sign_q=A[31]^B[31], sign_r=A[31];
    - clear the 33-bit partial remainder R and counter; go to RUN.
  - ctrl_DIV=1 with B=0: go to DONE with result=0, remainder=A, exception=1.
  - ctrl_DIV=1 with A=0x80000000, B=-1: go to DONE with result=0x80000000, remainder=0, exception=1.
- **RUN**, each cycle:
  - R = {R[31:0], Q[31]}; Q <<= 1;
  - trial T = R − {0,|B|} through the shared add/subtract unit;
  - if T≥0, R=T and Q[0]=1; otherwise R is restored.
  - Counter increments. After iteration 32 go to DONE.
- **DONE** (one cycle):
  - data_result = sign_q ? −Q : Q; data_remainder = sign_r ? −R : R; exception=0 for normal runs.
  - data_resultRDY=1; next state IDLE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- ctrl_DIV=1 in RUN or DONE aborts the current operation and restarts with the new operands (same entry rules as IDLE). No ready pulse is issued for the aborted operation.
- |0x80000000| is handled as unsigned 0x80000000 in the 32-bit magnitude path.

## Timing
- Reset: state=IDLE. data_result, data_remainder, data_exception, data_resultRDY and busy are all 0. Reset overrides ctrl_DIV in the same cycle.
- Normal latency:
  - start sampled at edge E0; iterations at E1..E32;
  - outputs registered at E33; data_resultRDY high from E33 to E34.
- Exception latency: outputs registered at E1; ready high from E1 to E2.
- busy is high from E0 to E32 inclusive for normal operations, and never high for exception cases.
- Reset mid-RUN: returns to IDLE at the next edge with no ready pulse, and all outputs clear.
- Outputs change only in DONE, on an exception entry, or on reset.

## Structure
- Shared package `multdiv_pkg`:
  - state enum (IDLE/RUN/DONE);
  - DIV_ITER=32;
  - constants INT_MIN=32'h80000000 and NEG_ONE=32'hFFFFFFFF.
- Trial subtraction reuses the existing 32-bit CLA add/subtract block (addCalc with subTrue=1), applied to R[31:0] and |B|. The borrow is derived from R[32] and the carry-out.
- One natural sub-module, `div_iter`: a combinational single-step shift/trial/restore producing next R and Q.
- Negation for sign fix-up is a local two's-complement.

## Test plan
- A=100, B=7, start at E0 → at E33: result=14, remainder=2, exception=0, ready high for exactly 1 cycle.
- A=−100 (0xFFFFFF9C), B=7 → result=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE); also 100/−7 → −14 with remainder 2.
- A=5, B=0 → at E1: result=0, remainder=5, exception=1, ready pulse; busy stays 0.
- A=0x80000000, B=0xFFFFFFFF → at E1: result=0x80000000, exception=1. Also 0x80000000/1 → result=0x80000000 at E33, exception=0.
- Start 1000/3, assert reset at E10 → no ready pulse, all outputs 0, state IDLE. A subsequent 9/3 yields 3 at its own E33.
- Start 1000/3, then at E5 start 50/5 → a single ready pulse at E5+33 with result=10 and remainder=0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the multiply/divide unit.
//   divState_e : controller states of the sequential divider
//   DIV_ITER   : number of shift/subtract iterations (one quotient bit each)
//   INT_MIN    : most negative 32-bit two's-complement value
//   NEG_ONE    : all-ones divisor, which overflows when paired with INT_MIN
// ---------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_e;

    localparam int          DIV_ITER = 32;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE  = 32'hFFFF_FFFF;

endpackage

// File: rtl/addCalc.sv
// ---------------------------------------------------------------------------
// addCalc
// Combinational add/subtract datapath built from generate/propagate terms.
// Subtraction is A + ~B + 1, so carryOut=1 means "no borrow" (A >= B unsigned).
// Ports:
//   data_operandA, data_operandB : WIDTH-bit operands
//   subTrue                      : 1 = subtract B from A, 0 = add
//   data_result                  : WIDTH-bit sum/difference
//   carryOut                     : carry out of the top bit
// ---------------------------------------------------------------------------
module addCalc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             subTrue,
    output logic [WIDTH-1:0] data_result,
    output logic             carryOut
);

    logic [WIDTH-1:0] w_opB;
    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH:0]   w_carry;

    // Invert B for subtraction; the +1 enters as the carry-in below.
    assign w_opB  = subTrue ? ~data_operandB : data_operandB;
    assign w_gen  = data_operandA & w_opB;
    assign w_prop = data_operandA ^ w_opB;

    // Carry chain expressed as generate-or-propagate lookahead terms.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = subTrue;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i+1] = w_gen[i] | (w_prop[i] & w_carry[i]);
        end
    end

    assign data_result = w_prop ^ w_carry[WIDTH-1:0];
    assign carryOut    = w_carry[WIDTH];

endmodule

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
// Ports:
//   remIn    : current partial remainder (always < divisor, so WIDTH bits)
//   quoIn    : current quotient/dividend shift register
//   divisor  : divisor magnitude
//   remOut   : next partial remainder
//   quoOut   : next quotient/dividend shift register
// ---------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0]   w_remShift;
    logic [WIDTH-1:0] w_diff;
    logic             w_carry;
    logic             w_trialOk;

    // The 33-bit partial remainder exists only inside the step: after the
    // shift it can reach 2*divisor, but after subtract/restore it is again
    // below the divisor and fits in WIDTH bits.
    assign w_remShift = {remIn, quoIn[WIDTH-1]};

    addCalc #(.WIDTH(WIDTH)) u_trialSub (
        .data_operandA (w_remShift[WIDTH-1:0]),
        .data_operandB (divisor),
        .subTrue       (1'b1),
        .data_result   (w_diff),
        .carryOut      (w_carry)
    );

    // Trial result is non-negative when the top remainder bit covers the
    // borrow or when the low-word subtraction produced no borrow.
    assign w_trialOk = w_remShift[WIDTH] | w_carry;

    assign remOut = w_trialOk ? w_diff : w_remShift[WIDTH-1:0];
    assign quoOut = {quoIn[WIDTH-2:0], w_trialOk};

endmodule

// File: rtl/div_calc.sv
// ---------------------------------------------------------------------------
// div_calc
// Sequential signed divider: 32 restoring iterations on operand magnitudes,
// then sign fix-up (quotient truncates toward zero, remainder follows the
// dividend). Divide-by-zero and INT_MIN / -1 finish immediately with the
// exception flag set.
// Ports:
//   clock, reset                  : rising-edge clock, sync active-high reset
//   ctrl_DIV                      : start pulse (also aborts/restarts)
//   data_operandA, data_operandB  : dividend, divisor (two's complement)
//   data_result, data_remainder   : registered quotient and remainder
//   data_exception                : divide-by-zero or overflow
//   data_resultRDY                : one-cycle pulse when outputs update
//   busy                          : high while iterating
// ---------------------------------------------------------------------------
module div_calc
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    divState_e        r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [5:0]       r_count;
    logic             r_signQ;
    logic             r_signR;
    logic             r_exc;

    logic             w_divZero;
    logic             w_overflow;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;
    logic [WIDTH-1:0] w_quoFixed;
    logic [WIDTH-1:0] w_remFixed;

    // Classify the incoming operands; magnitudes treat INT_MIN as unsigned
    // 0x80000000, which the unsigned datapath handles naturally.
    assign w_divZero  = (data_operandB == '0);
    assign w_overflow = (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
    assign w_absA     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign w_absB     = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    div_iter #(.WIDTH(WIDTH)) u_divIter (
        .remIn   (r_rem),
        .quoIn   (r_quo),
        .divisor (r_divisor),
        .remOut  (w_remNext),
        .quoOut  (w_quoNext)
    );

    // Sign restoration applied when the finished magnitudes are published.
    assign w_quoFixed = r_signQ ? (~r_quo + WIDTH'(1)) : r_quo;
    assign w_remFixed = r_signR ? (~r_rem + WIDTH'(1)) : r_rem;

    // Controller: a start in any state wins and reloads the operands, so an
    // operation in flight is dropped without a ready pulse. Exception cases
    // preload their final answer with cleared signs and go straight to DONE,
    // which keeps a single output-publishing path.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rem          <= '0;
            r_quo          <= '0;
            r_divisor      <= '0;
            r_count        <= '0;
            r_signQ        <= 1'b0;
            r_signR        <= 1'b0;
            r_exc          <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                r_count <= '0;
                r_signQ <= 1'b0;
                r_signR <= 1'b0;
                if (w_divZero) begin
                    r_quo   <= '0;
                    r_rem   <= data_operandA;
                    r_exc   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= DONE;
                end else if (w_overflow) begin
                    r_quo   <= INT_MIN;
                    r_rem   <= '0;
                    r_exc   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= DONE;
                end else begin
                    r_quo     <= w_absA;
                    r_rem     <= '0;
                    r_divisor <= w_absB;
                    r_signQ   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    r_signR   <= data_operandA[WIDTH-1];
                    r_exc     <= 1'b0;
                    busy      <= 1'b1;
                    r_state   <= RUN;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    RUN: begin
                        r_rem   <= w_remNext;
                        r_quo   <= w_quoNext;
                        r_count <= r_count + 6'd1;
                        if (r_count == 6'(DIV_ITER - 1)) begin
                            busy    <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                    DONE: begin
                        data_result    <= w_quoFixed;
                        data_remainder <= w_remFixed;
                        data_exception <= r_exc;
                        data_resultRDY <= 1'b1;
                        r_state        <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_calc.sv
// ---------------------------------------------------------------------------
// tb_div_calc
// Self-checking bench for div_calc: directed corner cases, reset and abort
// scenarios, then randomized operands compared against a plain signed
// arithmetic reference.
// ---------------------------------------------------------------------------
module tb_div_calc;

    localparam logic [31:0] INT_MIN_C = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE_C = 32'hFFFF_FFFF;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checkCount;
    int errCount;

    div_calc #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from the arithmetic definition: SystemVerilog
    // signed division already truncates toward zero and gives the remainder
    // the dividend's sign.
    task automatic refModel(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r,
                            output logic exc, output int lat);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0; r = a; exc = 1'b1; lat = 1;
        end else if (a == INT_MIN_C && b == NEG_ONE_C) begin
            q = INT_MIN_C; r = 32'd0; exc = 1'b1; lat = 1;
        end else begin
            q = sa / sb; r = sa % sb; exc = 1'b0; lat = 33;
        end
    endtask

    // Called at a falling edge; the next rising edge samples the start.
    // Returns at the falling edge just after that sampling edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
    endtask

    // Start an operation, wait (bounded) for ready and check everything.
    task automatic runAndCheck(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expQ;
        logic [31:0] expR;
        logic        expExc;
        int          expLat;
        int          k;
        refModel(a, b, expQ, expR, expExc, expLat);
        applyStimulus(a, b);
        checkOutput({tag, "_busy"}, {31'd0, busy}, {31'd0, (expLat == 33)});
        k = 0;
        while (k < 40) begin
            @(negedge clock);
            k++;
            if (data_resultRDY) break;
        end
        checkOutput({tag, "_latency"}, 32'(k), 32'(expLat));
        checkOutput({tag, "_quot"}, data_result, expQ);
        checkOutput({tag, "_rem"}, data_remainder, expR);
        checkOutput({tag, "_exc"}, {31'd0, data_exception}, {31'd0, expExc});
        @(negedge clock);
        checkOutput({tag, "_rdyDrop"}, {31'd0, data_resultRDY}, 32'd0);
        checkOutput({tag, "_hold"}, data_result, expQ);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        int sel;

        checkCount    = 0;
        errCount      = 0;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_quot", data_result, 32'd0);
        checkOutput("rst_rem", data_remainder, 32'd0);
        checkOutput("rst_exc", {31'd0, data_exception}, 32'd0);
        checkOutput("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        $display("[TB] directed operations");
        runAndCheck("pos", 32'd100, 32'd7);
        runAndCheck("negA", 32'hFFFF_FF9C, 32'd7);
        runAndCheck("negB", 32'd100, 32'hFFFF_FFF9);
        runAndCheck("bothNeg", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        runAndCheck("divZero", 32'd5, 32'd0);
        runAndCheck("ovf", INT_MIN_C, NEG_ONE_C);
        runAndCheck("minByOne", INT_MIN_C, 32'd1);
        runAndCheck("minByMin", INT_MIN_C, INT_MIN_C);
        runAndCheck("smallByBig", 32'd3, 32'd1000);

        $display("[TB] reset during RUN");
        applyStimulus(32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midRst_quot", data_result, 32'd0);
        checkOutput("midRst_rem", data_remainder, 32'd0);
        checkOutput("midRst_exc", {31'd0, data_exception}, 32'd0);
        checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        checkOutput("midRst_noPulse", 32'(pulses), 32'd0);
        runAndCheck("afterRst", 32'd9, 32'd3);

        $display("[TB] abort and restart");
        applyStimulus(32'd1000, 32'd3);
        repeat (4) @(negedge clock);
        runAndCheck("abort", 32'd50, 32'd5);

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                rb = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            end else if (sel == 4) begin
                rb = 32'd0;
            end else if (sel == 5) begin
                rb = NEG_ONE_C;
                if ($urandom_range(0, 1) == 1) ra = INT_MIN_C;
            end else begin
                rb = $urandom;
                if (rb == 32'd0) rb = 32'd1;
                if (sel == 9) rb = rb >> $urandom_range(8, 24);
                if (rb == 32'd0) rb = 32'd3;
            end
            runAndCheck($sformatf("rnd%0d", n), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
